cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
- Sequences CPU execution by generating the single-cycle `enable` strobe that advances the core one instruction.
- Supports free-run at a slow or turbo rate, pause, single-step, and an instruction-pointer breakpoint.
- Sits between the debounced front-panel inputs and the cpu `enable` input.
- Watches the cpu instruction pointer to halt before a selected address executes.

Parameters:
- SLOW_DIV, 8388608: clock cycles per enable pulse in normal run mode (≥2).
- FAST_DIV, 1: clock cycles per enable pulse in turbo mode (≥1; 1 = every cycle).
- CNT_W, 24: divider counter width; must hold SLOW_DIV-1.
- RESET_RUN, 1: state after reset; 1 = RUN, 0 = IDLE.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- run_req  input  1  one-cycle pulse: start/resume free-run.
- pause_req  input  1  one-cycle pulse: stop free-run.
- step_req  input  1  one-cycle pulse: execute exactly one instruction.
- turbo  input  1  level: 1 selects FAST_DIV, 0 selects SLOW_DIV.
- bp_en  input  1  level: breakpoint armed.
- bp_addr  input  8  breakpoint instruction address.
- ip  input  8  current cpu instruction pointer.
- enable_out  output  1  one-cycle cpu advance strobe.
- running  output  1  high in RUN state.
- halted_bp  output  1  high in BREAK state.
- step_count  output  16  number of enable_out pulses issued; wraps.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - enable_out=0, step_count=0, divider count=0, skip_bp=0, halted_bp=0.
  - State = RUN if RESET_RUN else IDLE; running follows the state.
- States: IDLE, RUN, STEP, BREAK. All outputs are registered.
- Request priority in a given cycle: pause_req > step_req > run_req. Lower-priority requests in that cycle are dropped, not queued.
- Divider (RUN only):
  - period = turbo ? FAST_DIV : SLOW_DIV.
  - Count increments every cycle. When count ≥ period-1, the next cycle asserts enable_out and the count returns to 0.
  - Using ≥ means a slow→turbo switch mid-count fires on the next cycle; no lockout.
  - Outside RUN the count is held at 0.
- Breakpoint:
  - On a cycle where RUN would fire, if bp_en && ip==bp_addr && !skip_bp, the pulse is suppressed. Next state is BREAK and halted_bp=1.
  - The instruction at bp_addr has not executed.
- skip_bp:
  - Set when leaving BREAK via run_req or step_req.
  - Cleared on the next issued enable_out pulse, so resume does not re-trap on the same address.
- IDLE:
  - run_req → RUN, count=0.
  - step_req → STEP.
  - pause_req: no effect.
- RUN:
  - pause_req → IDLE, count cleared. No pulse in that cycle even if one was due.
  - step_req and run_req are ignored.
- STEP:
  - Lasts exactly one cycle: enable_out=1, then → IDLE.
  - Latency: step_req sampled at edge N gives enable_out high from edge N+1 to N+2.
  - Breakpoints are not checked on a step.
- BREAK:
  - run_req → RUN with skip_bp=1.
  - step_req → STEP with skip_bp=1.
  - pause_req → IDLE, halted_bp=0.
  - halted_bp=1 only in BREAK.
- step_count increments on every enable_out=1 cycle (RUN or STEP) and wraps 0xFFFF→0x0000.
- enable_out is never high on two consecutive cycles unless RUN with period=1.
- Reset mid-operation aborts immediately: any pending pulse is lost and the state returns to its reset value.
- bp_en deasserted while in BREAK does not leave BREAK; a request is required.

Test Plan (bench uses SLOW_DIV=4, FAST_DIV=1, RESET_RUN=0):
- Release reset, pulse run_req, turbo=0, bp_en=0 → enable_out high every 4th cycle; step_count=3 after 12 cycles of RUN; running=1.
- In RUN set turbo=1 at count=2 → pulse on next cycle, then enable_out high every cycle; pause_req → enable_out low next cycle, running=0, count held 0.
- IDLE, step_req at edge N → enable_out=1 for exactly one cycle after edge N+1, step_count +1, state IDLE; step_req during RUN → no extra pulse.
- bp_en=1, bp_addr=0x05, ip=0x05 while RUN → no pulse, halted_bp=1, running=0. Then:
  - run_req → next due pulse issues with ip still 0x05, halted_bp=0.
  - Re-entering 0x05 later re-traps.
- Same cycle: pause_req+step_req+run_req in IDLE → stays IDLE, no pulse. step_req+run_req → STEP only.
- Assert reset during RUN at count=2, and again with step_count=0xFFFF wrap test → all outputs at reset values asynchronously; step_count wraps to 0x0000 on the 65536th pulse.

Source files
------------

// File: rtl/cpu_run_controller.sv
// ----------------------------------------------------------------------------
// cpu_run_controller
//
// Generates the single-cycle `enable_out` strobe that advances the CPU core by
// one instruction. The core can free-run at a slow or turbo rate, be paused,
// be single-stepped, or be stopped by an instruction-pointer breakpoint. The
// breakpoint halts before the instruction at bp_addr executes.
//
// Parameters:
//   SLOW_DIV  - clock cycles per enable pulse in normal run mode (>= 2)
//   FAST_DIV  - clock cycles per enable pulse in turbo mode (>= 1)
//   CNT_W     - divider counter width, must hold SLOW_DIV-1
//   RESET_RUN - 1: come out of reset in RUN, 0: come out in IDLE
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   run_req    in   one-cycle pulse, start/resume free-run
//   pause_req  in   one-cycle pulse, stop free-run
//   step_req   in   one-cycle pulse, execute exactly one instruction
//   turbo      in   level, 1 selects FAST_DIV, 0 selects SLOW_DIV
//   bp_en      in   level, breakpoint armed
//   bp_addr    in   [7:0] breakpoint instruction address
//   ip         in   [7:0] current cpu instruction pointer
//   enable_out out  one-cycle cpu advance strobe
//   running    out  high in RUN state
//   halted_bp  out  high in BREAK state
//   step_count out  [15:0] number of enable_out pulses issued, wraps
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module cpu_run_controller #(
    parameter int unsigned SLOW_DIV  = 8388608,
    parameter int unsigned FAST_DIV  = 1,
    parameter int unsigned CNT_W     = 24,
    parameter bit          RESET_RUN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_req,
    input  logic        pause_req,
    input  logic        step_req,
    input  logic        turbo,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic [7:0]  ip,
    output logic        enable_out,
    output logic        running,
    output logic        halted_bp,
    output logic [15:0] step_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

    localparam logic [1:0] ST_RESET = RESET_RUN ? ST_RUN : ST_IDLE;

    // Terminal count values: the divider fires once count reaches period-1.
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             skip_bp_q, skip_bp_d;
    logic             pulse_d;

    logic [CNT_W-1:0] period_last;
    logic             due;
    logic             bp_hit;

    // A '>=' compare rather than '==' so that switching from slow to turbo
    // while the count is above the turbo terminal fires on the next cycle
    // instead of waiting for the counter to wrap.
    assign period_last = turbo ? FAST_LAST : SLOW_LAST;
    assign due         = (count_q >= period_last);

    // skip_bp masks the breakpoint for the first pulse after leaving BREAK,
    // so resuming does not immediately re-trap on the same address.
    assign bp_hit      = bp_en && (ip == bp_addr) && !skip_bp_q;

    always_comb begin
        state_d   = state_q;
        count_d   = '0;
        skip_bp_d = skip_bp_q;
        pulse_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // pause_req has top priority; in IDLE it simply swallows any
                // coincident step/run request.
                if (pause_req) begin
                    state_d = ST_IDLE;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end else if (run_req) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (pause_req) begin
                    // Any pulse due this cycle is dropped.
                    state_d = ST_IDLE;
                end else if (due) begin
                    if (bp_hit) begin
                        state_d = ST_BREAK;
                    end else begin
                        pulse_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end

            ST_STEP: begin
                // Breakpoints are deliberately not checked on a step.
                pulse_d = 1'b1;
                state_d = ST_IDLE;
            end

            ST_BREAK: begin
                if (pause_req) begin
                    state_d = ST_IDLE;
                end else if (step_req) begin
                    state_d   = ST_STEP;
                    skip_bp_d = 1'b1;
                end else if (run_req) begin
                    state_d   = ST_RUN;
                    skip_bp_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pulse_d) begin
            skip_bp_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            count_q    <= '0;
            skip_bp_q  <= 1'b0;
            enable_out <= 1'b0;
            running    <= (ST_RESET == ST_RUN);
            halted_bp  <= 1'b0;
            step_count <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            skip_bp_q  <= skip_bp_d;
            enable_out <= pulse_d;
            running    <= (state_d == ST_RUN);
            halted_bp  <= (state_d == ST_BREAK);
            if (pulse_d) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// ----------------------------------------------------------------------------
// tb_cpu_run_controller
//
// Table-driven bench for cpu_run_controller with SLOW_DIV=4, FAST_DIV=1,
// RESET_RUN=0. Each vector is one clock cycle of inputs plus the outputs
// expected just after that edge; expectations go through a queue and are
// popped when the DUT outputs are sampled. Reset-abort and 16-bit wrap are
// driven as hand-written sequences after the table.
// ----------------------------------------------------------------------------
module tb_cpu_run_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_req = 1'b0;
    logic        pause_req = 1'b0;
    logic        step_req = 1'b0;
    logic        turbo = 1'b0;
    logic        bp_en = 1'b0;
    logic [7:0]  bp_addr = 8'h05;
    logic [7:0]  ip = 8'h00;
    logic        enable_out;
    logic        running;
    logic        halted_bp;
    logic [15:0] step_count;

    cpu_run_controller #(
        .SLOW_DIV (4),
        .FAST_DIV (1),
        .CNT_W    (8),
        .RESET_RUN(1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run_req   (run_req),
        .pause_req (pause_req),
        .step_req  (step_req),
        .turbo     (turbo),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .ip        (ip),
        .enable_out(enable_out),
        .running   (running),
        .halted_bp (halted_bp),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        r, p, s, t, be;
        logic [7:0]  ip;
        logic        en, run, h;
        logic [15:0] sc;
    } vec_t;

    vec_t        vecs[$];
    logic [18:0] exp_q[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic add(input string name, input logic r, input logic p,
                       input logic s, input logic t, input logic be,
                       input logic [7:0] ipv, input logic en, input logic run,
                       input logic h, input logic [15:0] sc);
        vec_t v;
        v.name = name; v.r = r; v.p = p; v.s = s; v.t = t; v.be = be;
        v.ip = ipv; v.en = en; v.run = run; v.h = h; v.sc = sc;
        vecs.push_back(v);
    endtask

    task automatic expect_out(input logic en, input logic run, input logic h,
                              input logic [15:0] sc);
        exp_q.push_back({en, run, h, sc});
    endtask

    task automatic check(input string name);
        logic [18:0] got;
        logic [18:0] exp;
        got = {enable_out, running, halted_bp, step_count};
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: scoreboard empty, got en=%0b run=%0b halt=%0b sc=%04h",
                     name, got[18], got[17], got[16], got[15:0]);
        end else begin
            exp = exp_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_miss++;
                $display("FAIL %s: got en=%0b run=%0b halt=%0b sc=%04h, expected en=%0b run=%0b halt=%0b sc=%04h",
                         name, got[18], got[17], got[16], got[15:0],
                         exp[18], exp[17], exp[16], exp[15:0]);
            end
        end
    endtask

    // Drive one vector, clock it, sample #1 after the edge.
    task automatic apply(input vec_t v);
        run_req   = v.r;
        pause_req = v.p;
        step_req  = v.s;
        turbo     = v.t;
        bp_en     = v.be;
        ip        = v.ip;
        expect_out(v.en, v.run, v.h, v.sc);
        @(posedge clk);
        #1;
        check(v.name);
    endtask

    task automatic drive(input logic r, input logic p, input logic s,
                         input logic t);
        run_req = r; pause_req = p; step_req = s; turbo = t;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got no summary, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- vector table ----------------
        // Free-run slow: pulse every 4th cycle.
        add("idle",         0,0,0,0,0,8'h00, 0,0,0,16'd0);
        add("run_req",      1,0,0,0,0,8'h00, 0,1,0,16'd0);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++)
                add("slow_wait", 0,0,0,0,0,8'h00, 0,1,0,16'(k));
            add("slow_fire",    0,0,0,0,0,8'h00, 1,1,0,16'(k + 1));
        end
        // Turbo switch at count=2, then every cycle, then pause.
        add("pre_turbo",    0,0,0,0,0,8'h00, 0,1,0,16'd3);
        add("pre_turbo",    0,0,0,0,0,8'h00, 0,1,0,16'd3);
        add("turbo_switch", 0,0,0,1,0,8'h00, 1,1,0,16'd4);
        add("turbo_run",    0,0,0,1,0,8'h00, 1,1,0,16'd5);
        add("turbo_run",    0,0,0,1,0,8'h00, 1,1,0,16'd6);
        add("pause",        0,1,0,1,0,8'h00, 0,0,0,16'd6);
        add("idle_held",    0,0,0,0,0,8'h00, 0,0,0,16'd6);
        // Single step from IDLE; step_req in RUN ignored.
        add("step_req",     0,0,1,0,0,8'h00, 0,0,0,16'd6);
        add("step_pulse",   0,0,0,0,0,8'h00, 1,0,0,16'd7);
        add("step_done",    0,0,0,0,0,8'h00, 0,0,0,16'd7);
        add("run_req2",     1,0,0,0,0,8'h00, 0,1,0,16'd7);
        add("step_in_run",  0,0,1,0,0,8'h00, 0,1,0,16'd7);
        add("run_wait",     0,0,0,0,0,8'h00, 0,1,0,16'd7);
        add("run_wait",     0,0,0,0,0,8'h00, 0,1,0,16'd7);
        add("run_fire",     0,0,0,0,0,8'h00, 1,1,0,16'd8);
        // Breakpoint at 0x05.
        for (int j = 0; j < 3; j++)
            add("bp_wait",  0,0,0,0,1,8'h05, 0,1,0,16'd8);
        add("bp_trap",      0,0,0,0,1,8'h05, 0,0,1,16'd8);
        add("bp_en_off",    0,0,0,0,0,8'h05, 0,0,1,16'd8);
        add("bp_resume",    1,0,0,0,1,8'h05, 0,1,0,16'd8);
        for (int j = 0; j < 3; j++)
            add("skip_wait", 0,0,0,0,1,8'h05, 0,1,0,16'd8);
        add("skip_fire",    0,0,0,0,1,8'h05, 1,1,0,16'd9);
        for (int j = 0; j < 3; j++)
            add("ip6_wait", 0,0,0,0,1,8'h06, 0,1,0,16'd9);
        add("ip6_fire",     0,0,0,0,1,8'h06, 1,1,0,16'd10);
        for (int j = 0; j < 3; j++)
            add("ip5_wait", 0,0,0,0,1,8'h05, 0,1,0,16'd10);
        add("bp_retrap",    0,0,0,0,1,8'h05, 0,0,1,16'd10);
        add("bp_step",      0,0,1,0,1,8'h05, 0,0,0,16'd10);
        add("bp_step_pulse",0,0,0,0,1,8'h05, 1,0,0,16'd11);
        add("bp_step_done", 0,0,0,0,1,8'h05, 0,0,0,16'd11);
        add("run_req3",     1,0,0,0,1,8'h05, 0,1,0,16'd11);
        for (int j = 0; j < 3; j++)
            add("trap3_wait", 0,0,0,0,1,8'h05, 0,1,0,16'd11);
        add("trap3",        0,0,0,0,1,8'h05, 0,0,1,16'd11);
        add("bp_pause",     0,1,0,0,1,8'h05, 0,0,0,16'd11);
        // Same-cycle request priority.
        add("prio_all",     1,1,1,0,0,8'h00, 0,0,0,16'd11);
        add("prio_after",   0,0,0,0,0,8'h00, 0,0,0,16'd11);
        add("step_run",     1,0,1,0,0,8'h00, 0,0,0,16'd11);
        add("step_run_pulse",0,0,0,0,0,8'h00, 1,0,0,16'd12);
        add("step_run_done",0,0,0,0,0,8'h00, 0,0,0,16'd12);

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        expect_out(1'b0, 1'b0, 1'b0, 16'd0);
        check("reset_state");
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // ---------------- reset during RUN at count=2 ----------------
        drive(1, 0, 0, 0);
        expect_out(1'b0, 1'b1, 1'b0, 16'd12);
        @(posedge clk); #1; check("rst_run_req");
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        expect_out(1'b0, 1'b0, 1'b0, 16'd0);
        check("async_reset_run");
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        expect_out(1'b0, 1'b0, 1'b0, 16'd0);
        @(posedge clk); #1; check("post_reset_idle");

        // ---------------- step_count wrap in turbo ----------------
        drive(1, 0, 0, 1);
        expect_out(1'b0, 1'b1, 1'b0, 16'd0);
        @(posedge clk); #1; check("wrap_run_req");
        drive(0, 0, 0, 1);
        repeat (65535) @(posedge clk);
        #1;
        expect_out(1'b1, 1'b1, 1'b0, 16'hFFFF);
        check("wrap_ffff");
        expect_out(1'b1, 1'b1, 1'b0, 16'h0000);
        @(posedge clk); #1; check("wrap_zero");
        expect_out(1'b1, 1'b1, 1'b0, 16'h0001);
        @(posedge clk); #1; check("wrap_one");
        #3;
        reset = 1'b1;
        #1;
        expect_out(1'b0, 1'b0, 1'b0, 16'd0);
        check("async_reset_turbo");
        #2;
        reset = 1'b0;
        drive(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
